iob_mem_responder: RTL and testbench

IOB_MEM_RESPONDER -- requirements
Module: iob_mem_responder

---
 rtl/iob_mem_responder.sv | 133 +++++++++++++
 tb/tb_iob_mem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_mem_responder.sv
// Single-port word memory behind a valid/ready request interface.
// Each request is captured in IDLE and waits WAIT_STATES cycles. The memory
// access then happens on the edge that enters RESP, and a one-cycle ready
// pulse returns the read data.
module iob_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]      req,
    output logic [DATA_W:0]                      resp,
    output logic                                 busy
);

    localparam int         STRB_W = DATA_W / 8;
    localparam int         DEPTH  = 1 << MEM_ADDR_W;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_wstrb;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [MEM_ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  ready_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  go_resp;
    logic [MEM_ADDR_W-1:0] op_idx;
    logic [DATA_W-1:0]     op_wdata;
    logic [STRB_W-1:0]     op_wstrb;
    logic                  mem_we;
    logic                  unused_addr_bits;

    assign {req_valid, req_addr, req_wdata, req_wstrb} = req;

    // Byte offset and high address bits do not select a word; upper addresses alias.
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:MEM_ADDR_W+2], req_addr[1:0]};

    // RESP is entered either straight from IDLE (no wait states) or on the last WAIT cycle.
    assign go_resp = ((state_q == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    // With zero wait states the operation uses the live request, since capture happens on the same edge.
    always_comb begin
        op_idx   = idx_q;
        op_wdata = wdata_q;
        op_wstrb = wstrb_q;
        if (state_q == ST_IDLE) begin
            op_idx   = req_addr[MEM_ADDR_W+1:2];
            op_wdata = req_wdata;
            op_wstrb = req_wstrb;
        end
    end

    // A write still pending while reset is applied is dropped.
    assign mem_we = go_resp && (op_wstrb != '0) && !rst;

    // Sequencer: capture in IDLE, count down in WAIT, one-cycle RESP with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= go_resp;
            rdata_q <= '0;
            if (go_resp && (op_wstrb == '0)) begin
                rdata_q <= mem_q[op_idx];
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_addr[MEM_ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WS_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory contents survive reset; only byte lanes with a set strobe are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (op_wstrb[i]) begin
                    mem_q[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp = {rdata_q, ready_q};
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_mem_responder.sv
// Four responders with WAIT_STATES = 1, 0, 3, 2 share one clock.
// Expected read data is queued when a request is driven and compared when ready pulses.
module tb_iob_mem_responder;

    localparam int          N_DUT   = 4;
    localparam int          REQ_W   = 1 + 32 + 32 + 4;
    localparam logic [15:0] WS_PACK = {4'd2, 4'd3, 4'd0, 4'd1};

    logic             clk = 1'b0;
    logic             rst_a  [N_DUT];
    logic [REQ_W-1:0] req_a  [N_DUT];
    logic [32:0]      resp_a [N_DUT];
    logic             busy_a [N_DUT];

    logic [31:0] model_mem [N_DUT][1024];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        iob_mem_responder #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_ADDR_W  (10),
            .WAIT_STATES (int'(WS_PACK[4*g +: 4]))
        ) u_dut (
            .clk  (clk),
            .rst  (rst_a[g]),
            .req  (req_a[g]),
            .resp (resp_a[g]),
            .busy (busy_a[g])
        );
    end

    always #5 clk = ~clk;

    task automatic drive(input int d, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        req_a[d] = {v, a, wd, ws};
    endtask

    task automatic model_write(input int d, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [9:0] idx;
        idx = addr[11:2];
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) model_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
        end
    endtask

    // One complete transaction. Checks idle state, latency, busy, rdata==0 off-pulse and the scoreboard data.
    task automatic txn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit use_lit, input logic [31:0] exp_lit,
                       input string name);
        int          ws;
        logic [31:0] exp_v;
        logic [31:0] got;
        logic [31:0] want;
        bit          seen;
        ws = int'(WS_PACK[4*d +: 4]);
        @(posedge clk); #1;
        n_checks++;
        if (resp_a[d][0] !== 1'b0 || busy_a[d] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle: ready=%b busy=%b, required 0 0", name, resp_a[d][0], busy_a[d]);
        end
        if (wstrb != 4'h0) begin
            exp_v = 32'h0;
            model_write(d, addr, wdata, wstrb);
        end else begin
            exp_v = model_mem[d][addr[11:2]];
        end
        if (use_lit) exp_v = exp_lit;
        sb_q.push_back(exp_v);
        drive(d, 1'b1, addr, wdata, wstrb);
        seen = 1'b0;
        for (int c = 1; c <= ws + 4 && !seen; c++) begin
            @(posedge clk); #1;
            if (resp_a[d][0] === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (c != ws + 1) begin
                    n_errors++;
                    $display("FAIL %s latency: ready in cycle %0d, required %0d", name, c, ws + 1);
                end
                n_checks++;
                if (busy_a[d] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s busy_resp: got %b, required 1", name, busy_a[d]);
                end
                got  = resp_a[d][32:1];
                want = sb_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL %s rdata: got %h, required %h", name, got, want);
                end
                drive(d, 1'b0, addr, wdata, wstrb);
            end else begin
                got = resp_a[d][32:1];
                n_checks++;
                if (got !== 32'h0) begin
                    n_errors++;
                    $display("FAIL %s rdata_idle: got %h, required 0", name, got);
                end
                if (c <= ws) begin
                    n_checks++;
                    if (busy_a[d] !== 1'b1) begin
                        n_errors++;
                        $display("FAIL %s busy_wait: got %b, required 1", name, busy_a[d]);
                    end
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no ready within %0d cycles, required cycle %0d", name, ws + 4, ws + 1);
            void'(sb_q.pop_front());
            drive(d, 1'b0, addr, wdata, wstrb);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < N_DUT; d++) begin
            rst_a[d] = 1'b1;
            drive(d, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            n_checks++;
            if (resp_a[d] !== 33'h0 || busy_a[d] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: resp=%h busy=%b, required 0 0", d, resp_a[d], busy_a[d]);
            end
        end
        for (int d = 0; d < N_DUT; d++) rst_a[d] = 1'b0;
    endtask

    task automatic test_write_read();
        txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, "wr_0x10");
        txn(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, "rd_0x10");
    endtask

    task automatic test_partial_strobe();
        txn(0, 32'h50, 32'h11223344, 4'hF, 1'b1, 32'h0, "init_0x50");
        txn(0, 32'h50, 32'hAABBCCDD, 4'h6, 1'b1, 32'h0, "wr6_0x50");
        txn(0, 32'h50, 32'h0, 4'h0, 1'b1, 32'h11BBCC44, "rd_partial");
    endtask

    task automatic test_alias();
        txn(0, 32'h0000_1004, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0, "wr_alias");
        txn(0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, 32'h5A5A5A5A, "rd_alias");
    endtask

    task automatic test_back_to_back();
        txn(1, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b1, 32'h0, "b2b_wr0");
        txn(1, 32'h4, 32'hB1B1B1B1, 4'hF, 1'b1, 32'h0, "b2b_wr4");
        txn(1, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA0A0A0A0, "b2b_rd0");
        txn(1, 32'h4, 32'h0, 4'h0, 1'b1, 32'hB1B1B1B1, "b2b_rd4");
    endtask

    task automatic test_reset_inflight();
        txn(2, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, "pre_0x20");
        @(posedge clk); #1;
        drive(2, 1'b1, 32'h20, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        n_checks++;
        if (busy_a[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL inflight_busy: got %b, required 1", busy_a[2]);
        end
        @(posedge clk); #1;
        rst_a[2] = 1'b1;
        drive(2, 1'b0, 32'h20, 32'h12345678, 4'hF);
        #1;
        n_checks++;
        if (busy_a[2] !== 1'b0 || resp_a[2] !== 33'h0) begin
            n_errors++;
            $display("FAIL inflight_rst: busy=%b resp=%h, required 0 0", busy_a[2], resp_a[2]);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_a[2][0] !== 1'b0) begin
                n_errors++;
                $display("FAIL inflight_noready: ready=%b, required 0", resp_a[2][0]);
            end
        end
        rst_a[2] = 1'b0;
        txn(2, 32'h20, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, "rd_after_abort");
    endtask

    task automatic test_valid_drop();
        logic [31:0] got;
        logic [31:0] want;
        txn(3, 32'h40, 32'h11111111, 4'hF, 1'b0, 32'h0, "pre_0x40");
        txn(3, 32'h44, 32'h44444444, 4'hF, 1'b0, 32'h0, "pre_0x44");
        txn(3, 32'h48, 32'h48484848, 4'hF, 1'b0, 32'h0, "pre_0x48");
        @(posedge clk); #1;
        sb_q.push_back(32'h0);
        model_write(3, 32'h40, 32'h600DF00D, 4'hF);
        drive(3, 1'b1, 32'h40, 32'h600DF00D, 4'hF);
        @(posedge clk); #1;
        n_checks++;
        if (resp_a[3][0] !== 1'b0 || busy_a[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_c1: ready=%b busy=%b, required 0 1", resp_a[3][0], busy_a[3]);
        end
        drive(3, 1'b0, 32'h44, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        n_checks++;
        if (resp_a[3][0] !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_c2: ready=%b, required 0", resp_a[3][0]);
        end
        drive(3, 1'b1, 32'h48, 32'h0, 4'hF);
        @(posedge clk); #1;
        n_checks++;
        if (resp_a[3][0] !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_c3: ready=%b, required 1", resp_a[3][0]);
        end
        got  = resp_a[3][32:1];
        want = sb_q.pop_front();
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL drop_rdata: got %h, required %h", got, want);
        end
        drive(3, 1'b0, 32'h48, 32'h0, 4'h0);
        txn(3, 32'h40, 32'h0, 4'h0, 1'b1, 32'h600DF00D, "rd_captured");
        txn(3, 32'h44, 32'h0, 4'h0, 1'b1, 32'h44444444, "rd_untouched44");
        txn(3, 32'h48, 32'h0, 4'h0, 1'b1, 32'h48484848, "rd_untouched48");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int d = 0; d < N_DUT; d++) begin
            for (int w = 0; w < 8; w++) begin
                txn(d, 32'h200 + 32'(w * 4), $urandom, 4'hF, 1'b0, 32'h0, "rnd_init");
            end
            for (int k = 0; k < 16; k++) begin
                addr = ($urandom & 32'hFFFF_F000) | 32'h200 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
                txn(d, addr, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0, "rnd_op");
            end
        end
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            rst_a[d] = 1'b1;
            req_a[d] = '0;
        end
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_alias();
        test_back_to_back();
        test_reset_inflight();
        test_valid_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
